// File: rtl/fifo_uart_pkg.sv
// ---------------------------------------------------------------------------
// fifo_uart_pkg
// Shared definitions for the FIFO-fed UART transmitter.
//   - ST_* localparams: 3-bit encodings of the transmitter FSM states.
//   - tx_state_e: FSM state type built on those encodings.
//   - clks_per_bit_legal / stop_bits_legal: parameter legality helpers,
//     evaluated at elaboration time by the top level.
// ---------------------------------------------------------------------------
package fifo_uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FETCH = 3'd1;
    localparam logic [2:0] ST_START = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_STOP  = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_FETCH = ST_FETCH,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP
    } tx_state_e;

    // A bit period must contain at least two clocks so that the baud counter
    // is at least one bit wide and bit_end is low while it is held cleared.
    function automatic bit clks_per_bit_legal(input int clks);
        return (clks >= 2);
    endfunction

    function automatic bit stop_bits_legal(input int stop_bits);
        return (stop_bits == 1) || (stop_bits == 2);
    endfunction

endpackage

// File: rtl/fifo_uart_tx_baud_cnt.sv
// ---------------------------------------------------------------------------
// uart_baud_cnt
// Bit-period timer for the UART transmitter. Counts 0..CLKS_PER_BIT-1 and
// wraps on its own at each bit boundary.
//   clk      in   rising-edge clock
//   reset    in   synchronous active-high reset (counter to 0)
//   clear    in   hold the counter at 0 (used while no frame is on the line)
//   bit_end  out  high on the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign bit_end = (cnt_q == CNT_LAST);

    // Wrap explicitly at CNT_LAST so non-power-of-two bit periods work.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || bit_end) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
// Drains words from an upstream synchronous FIFO and sends each one as a
// UART frame: one start bit (0), DATA_W data bits LSB first, STOP_BITS stop
// bits (1). One frame per popped word; the line gives no handshake back.
//   clk         in   rising-edge clock
//   reset       in   synchronous active-high reset
//   enable      in   allows a new word to be fetched (looked at in IDLE only)
//   fifo_empty  in   FIFO empty flag
//   fifo_dout   in   FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en  out  one-cycle pop request per word
//   tx          out  serial line, idles high
//   busy        out  high whenever the FSM is not in IDLE
//   byte_done   out  one-cycle pulse on the final stop-bit cycle
// ---------------------------------------------------------------------------
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_dout,
    output logic              fifo_rd_en,
    output logic              tx,
    output logic              busy,
    output logic              byte_done
);

    if (!clks_per_bit_legal(CLKS_PER_BIT)) begin : g_bad_clks_per_bit
        $error("fifo_uart_tx: CLKS_PER_BIT must be at least 2");
    end
    if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
        $error("fifo_uart_tx: STOP_BITS must be 1 or 2");
    end

    localparam int BIT_W = $clog2(DATA_W + 1);
    localparam logic [BIT_W-1:0] LAST_DATA_BIT = BIT_W'(DATA_W - 1);
    localparam logic [BIT_W-1:0] LAST_STOP_BIT = BIT_W'(STOP_BITS - 1);

    tx_state_e         state_q,   state_d;
    logic [DATA_W-1:0] shreg_q,   shreg_d;
    logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic              bit_end;
    logic              baud_clear;
    logic              rd_req;

    // Baud counter is held at 0 outside a frame so START always gets a full
    // bit period counted from the cycle after FETCH.
    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_end (bit_end)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    // bit_cnt_q is reused: it counts data bits in DATA and stop bits in STOP.
    // rd_req includes ~reset so no word is popped (and lost) while the FSM
    // is being forced back to IDLE.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        rd_req     = 1'b0;
        byte_done  = 1'b0;
        baud_clear = 1'b0;
        tx         = 1'b1;

        case (state_q)
            S_IDLE: begin
                baud_clear = 1'b1;
                bit_cnt_d  = '0;
                rd_req     = enable & ~fifo_empty & ~reset;
                if (rd_req) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                baud_clear = 1'b1;
                shreg_d    = fifo_dout;
                bit_cnt_d  = '0;
                state_d    = S_START;
            end
            S_START: begin
                tx = 1'b0;
                if (bit_end) begin
                    bit_cnt_d = '0;
                    state_d   = S_DATA;
                end
            end
            S_DATA: begin
                tx = shreg_q[0];
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_cnt_q == LAST_DATA_BIT) begin
                        bit_cnt_d = '0;
                        state_d   = S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    if (bit_cnt_q == LAST_STOP_BIT) begin
                        byte_done = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = S_IDLE;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign fifo_rd_en = rd_req;
    assign busy       = (state_q != S_IDLE);

endmodule
